// File: rtl/param_seq_fsm.sv
// Parametrised sequence detector with KMP-style fallback, optional overlap,
// and a saturating match counter with a sticky overflow flag.
module param_seq_fsm #(
    parameter int SYM_W   = 2,
    parameter int SEQ_LEN = 4,
    parameter int CNT_W   = 2,
    parameter int ST_W    = $clog2(SEQ_LEN + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sym_valid,
    input  logic [SYM_W-1:0]         sym,
    input  logic                     cfg_load,
    input  logic [SEQ_LEN*SYM_W-1:0] cfg_pattern,
    input  logic                     overlap_en,
    input  logic                     clr_count,
    output logic                     match,
    output logic [CNT_W-1:0]         count,
    output logic                     count_ovf,
    output logic [ST_W-1:0]          state
);
    localparam int HL = SEQ_LEN - 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SEQ_LEN*SYM_W-1:0]     pat_q, pat_d;
    logic [HL-1:0][SYM_W-1:0]     hist_q, hist_d;
    logic [ST_W-1:0]              hist_len_q, hist_len_d;
    logic [ST_W-1:0]              state_q, state_d;
    logic                         match_q, match_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic                         ovf_q, ovf_d;

    // Oldest symbol at index 0, incoming symbol at the top.
    logic [SEQ_LEN-1:0][SYM_W-1:0] win;
    logic [SEQ_LEN:0]              hit;
    int                            avail;
    int                            k_full;
    int                            k_part;
    logic                          done;

    assign win = {sym, hist_q};

    always_comb begin
        avail  = int'(hist_len_q) + 1;
        hit    = '0;
        hit[0] = 1'b1;
        for (int k = 1; k <= SEQ_LEN; k++) begin
            hit[k] = (k <= avail);
            for (int j = 0; j < k; j++) begin
                if (win[SEQ_LEN-k+j] != pat_q[j*SYM_W +: SYM_W]) begin
                    hit[k] = 1'b0;
                end
            end
        end
        k_full = 0;
        k_part = 0;
        for (int k = 1; k <= SEQ_LEN; k++) begin
            if (hit[k]) begin
                k_full = k;
                if (k < SEQ_LEN) begin
                    k_part = k;
                end
            end
        end
    end

    assign done = sym_valid && !cfg_load && (k_full == SEQ_LEN);

    always_comb begin
        pat_d      = pat_q;
        hist_d     = hist_q;
        hist_len_d = hist_len_q;
        state_d    = state_q;
        match_d    = 1'b0;
        if (cfg_load) begin
            pat_d      = cfg_pattern;
            state_d    = '0;
            hist_len_d = '0;
        end else if (sym_valid) begin
            hist_d = win[SEQ_LEN-1:1];
            if (int'(hist_len_q) < HL) begin
                hist_len_d = hist_len_q + 1'b1;
            end
            if (done) begin
                match_d = 1'b1;
                if (overlap_en) begin
                    state_d = ST_W'(k_part);
                end else begin
                    state_d    = '0;
                    hist_len_d = '0;
                end
            end else begin
                state_d = ST_W'(k_full);
            end
        end
    end

    // A clear on the same edge as a match still counts that match.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clr_count) begin
            count_d = done ? CNT_W'(1) : '0;
            ovf_d   = 1'b0;
        end else if (done) begin
            if (count_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_q      <= '0;
            hist_q     <= '0;
            hist_len_q <= '0;
            state_q    <= '0;
            match_q    <= 1'b0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            pat_q      <= pat_d;
            hist_q     <= hist_d;
            hist_len_q <= hist_len_d;
            state_q    <= state_d;
            match_q    <= match_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

    assign match     = match_q;
    assign count     = count_q;
    assign count_ovf = ovf_q;
    assign state     = state_q;

endmodule

// File: tb/tb_param_seq_fsm.sv
// Self-checking bench for param_seq_fsm: directed scenarios plus random
// traffic against a queue-based suffix/prefix reference model.
module tb_param_seq_fsm;
    localparam int SYM_W   = 2;
    localparam int SEQ_LEN = 4;
    localparam int CNT_W   = 2;
    localparam int ST_W    = $clog2(SEQ_LEN + 1);
    localparam int CMAX    = (1 << CNT_W) - 1;
    localparam int PW      = SEQ_LEN * SYM_W;

    logic             clk = 1'b0;
    logic             reset;
    logic             sym_valid;
    logic [SYM_W-1:0] sym;
    logic             cfg_load;
    logic [PW-1:0]    cfg_pattern;
    logic             overlap_en;
    logic             clr_count;
    logic             match;
    logic [CNT_W-1:0] count;
    logic             count_ovf;
    logic [ST_W-1:0]  state;

    param_seq_fsm #(
        .SYM_W(SYM_W),
        .SEQ_LEN(SEQ_LEN),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sym_valid(sym_valid),
        .sym(sym),
        .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern),
        .overlap_en(overlap_en),
        .clr_count(clr_count),
        .match(match),
        .count(count),
        .count_ovf(count_ovf),
        .state(state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int m_pat[SEQ_LEN];
    int m_q[$];
    int m_state;
    int m_count;
    int m_ovf;
    int m_match;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] mkpat(input int p0, input int p1,
                                            input int p2, input int p3);
        logic [PW-1:0] v;
        v = '0;
        v[0*SYM_W +: SYM_W] = SYM_W'(p0);
        v[1*SYM_W +: SYM_W] = SYM_W'(p1);
        v[2*SYM_W +: SYM_W] = SYM_W'(p2);
        v[3*SYM_W +: SYM_W] = SYM_W'(p3);
        return v;
    endfunction

    // Longest k <= maxk such that the last k accepted symbols spell pattern[0..k-1].
    function automatic int best(input int maxk);
        int r;
        int n;
        bit ok;
        r = 0;
        n = m_q.size();
        for (int k = 1; k <= maxk && k <= n; k++) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++) begin
                if (m_q[n-k+j] != m_pat[j]) ok = 1'b0;
            end
            if (ok) r = k;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < SEQ_LEN; i++) m_pat[i] = 0;
        m_q.delete();
        m_state = 0;
        m_count = 0;
        m_ovf   = 0;
        m_match = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".match"}, int'(match), m_match);
        chk({tag, ".state"}, int'(state), m_state);
        chk({tag, ".count"}, int'(count), m_count);
        chk({tag, ".ovf"}, int'(count_ovf), m_ovf);
    endtask

    task automatic step(input string tag, input bit v, input int s,
                        input bit ld, input logic [PW-1:0] pat,
                        input bit ov, input bit clr);
        int k;
        bit hit;
        @(negedge clk);
        sym_valid   = v;
        sym         = SYM_W'(s);
        cfg_load    = ld;
        cfg_pattern = pat;
        overlap_en  = ov;
        clr_count   = clr;
        @(posedge clk);
        hit     = 1'b0;
        m_match = 0;
        if (ld) begin
            for (int i = 0; i < SEQ_LEN; i++) m_pat[i] = int'(pat[i*SYM_W +: SYM_W]);
            m_q.delete();
            m_state = 0;
        end else if (v) begin
            m_q.push_back(s);
            if (m_q.size() > SEQ_LEN) void'(m_q.pop_front());
            k = best(SEQ_LEN);
            if (k == SEQ_LEN) begin
                hit     = 1'b1;
                m_match = 1;
                if (ov) begin
                    m_state = best(SEQ_LEN - 1);
                end else begin
                    m_state = 0;
                    m_q.delete();
                end
            end else begin
                m_state = k;
            end
        end
        if (clr) begin
            m_count = hit ? 1 : 0;
            m_ovf   = 0;
        end else if (hit) begin
            if (m_count == CMAX) m_ovf = 1;
            else m_count++;
        end
        #1;
        check_all(tag);
    endtask

    task automatic put(input string tag, input int s, input bit ov);
        step(tag, 1'b1, s, 1'b0, '0, ov, 1'b0);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic load(input string tag, input logic [PW-1:0] p, input bit clr);
        step(tag, 1'b0, 0, 1'b1, p, 1'b0, clr);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        sym_valid = 1'b0;
        cfg_load  = 1'b0;
        clr_count = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        reset = 1'b1;
    endtask

    int t1_st[6] = '{1, 2, 3, 2, 3, 2};
    int t4_cnt[5] = '{1, 2, 3, 3, 3};
    int t4_ovf[5] = '{0, 0, 0, 1, 1};
    int t1_seq[6] = '{1, 2, 1, 2, 1, 2};

    initial begin
        logic [PW-1:0] rp;
        reset       = 1'b0;
        sym_valid   = 1'b0;
        sym         = '0;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        overlap_en  = 1'b0;
        clr_count   = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 1'b1;

        // Overlapping detection
        load("t1.load", mkpat(1, 2, 1, 2), 1'b0);
        for (int i = 0; i < 6; i++) begin
            put("t1", t1_seq[i], 1'b1);
            chk("t1.state_seq", int'(state), t1_st[i]);
        end
        chk("t1.count_fixed", int'(count), 2);

        // Non-overlapping detection
        load("t2.load", mkpat(1, 2, 1, 2), 1'b1);
        for (int i = 0; i < 6; i++) put("t2", t1_seq[i], 1'b0);
        chk("t2.state_end", int'(state), 2);
        chk("t2.count_fixed", int'(count), 1);

        // KMP fallback
        load("t3.load", mkpat(1, 1, 1, 2), 1'b1);
        put("t3", 1, 1'b0);
        put("t3", 1, 1'b0);
        put("t3", 1, 1'b0);
        put("t3", 1, 1'b0);
        chk("t3.fallback_state", int'(state), 3);
        put("t3", 2, 1'b0);
        chk("t3.match_fixed", int'(match), 1);
        chk("t3.count_fixed", int'(count), 1);

        // Saturation and clear colliding with a match
        load("t4.load", mkpat(1, 2, 1, 2), 1'b1);
        for (int m = 0; m < 5; m++) begin
            for (int i = 0; i < 4; i++) put("t4", t1_seq[i], 1'b0);
            chk("t4.count_sat", int'(count), t4_cnt[m]);
            chk("t4.ovf_sticky", int'(count_ovf), t4_ovf[m]);
        end
        put("t4", 1, 1'b0);
        put("t4", 2, 1'b0);
        put("t4", 1, 1'b0);
        step("t4.clr_hit", 1'b1, 2, 1'b0, '0, 1'b0, 1'b1);
        chk("t4.clr_count", int'(count), 1);
        chk("t4.clr_ovf", int'(count_ovf), 0);

        // Reset and reload mid-sequence
        put("t5", 1, 1'b0);
        put("t5", 2, 1'b0);
        put("t5", 1, 1'b0);
        async_reset("t5.rst");
        put("t5.after_rst", 2, 1'b0);
        chk("t5.no_match", int'(match), 0);
        load("t5.load", mkpat(1, 2, 1, 2), 1'b0);
        put("t5", 1, 1'b0);
        put("t5", 2, 1'b0);
        put("t5", 1, 1'b0);
        step("t5.ld_and_sym", 1'b1, 2, 1'b1, mkpat(1, 2, 1, 2), 1'b0, 1'b0);
        chk("t5.ld_state", int'(state), 0);
        chk("t5.ld_match", int'(match), 0);

        // Idle gaps between symbols
        for (int i = 0; i < 4; i++) begin
            put("t6", t1_seq[i], 1'b0);
            if (i < 3) for (int g = 0; g < 3; g++) idle("t6.gap");
        end
        chk("t6.match_fixed", int'(match), 1);
        idle("t6.after");

        // Random traffic with a small alphabet so matches are frequent
        rp = mkpat(0, 1, 0, 1);
        load("rnd.load", rp, 1'b1);
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                rp = mkpat(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                           int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
                step("rnd", $urandom_range(0, 1) == 1, int'($urandom_range(0, 1)),
                     1'b1, rp, 1'b0, $urandom_range(0, 3) == 0);
            end else begin
                step("rnd", r < 80, int'($urandom_range(0, r < 10 ? 3 : 1)),
                     1'b0, '0, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 39) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/param_seq_fsm.md
Name: param_seq_fsm

Overview:
Parametrised sequence-detector FSM. It accepts a stream of SYM_W-bit symbols and detects a programmable SEQ_LEN-symbol pattern, with optional overlapping detection. Completed detections go into a saturating match counter with a sticky overflow flag. It is the generalised successor of the team's fixed 2-input, 2-bit-count detector and sits on the same stimulus/assertion-bound verification path.

Parameters:
SYM_W, 2, width of one input symbol (>=1)
SEQ_LEN, 4, pattern length in symbols (>=2)
CNT_W, 2, width of the saturating match counter (>=1)
ST_W, $clog2(SEQ_LEN+1), width of the progress/state output (derived; not overridden)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
sym_valid  in  1  sym is accepted on this edge when high
sym  in  SYM_W  input symbol
cfg_load  in  1  load cfg_pattern and restart detection
cfg_pattern  in  SEQ_LEN*SYM_W  step i at [i*SYM_W +: SYM_W]; step 0 is the first symbol
overlap_en  in  1  1 = overlapping detection, 0 = restart after each match
clr_count  in  1  synchronous clear of count and count_ovf
match  out  1  one-cycle pulse per completed pattern
count  out  CNT_W  saturating number of matches
count_ovf  out  1  sticky; set when a match occurs while count is at max
state  out  ST_W  current progress k (symbols of the pattern matched so far, 0..SEQ_LEN-1)

Behaviour:
- Reset (reset=0, async): pattern register=0, state=0, history empty (hist_len=0), match=0, count=0, count_ovf=0.
- History: a shift register holds the last SEQ_LEN-1 accepted symbols plus hist_len (saturates at SEQ_LEN-1). Only symbols accepted since the last restart count toward a match.
- On an edge with sym_valid=1 and cfg_load=0, with H = history followed by sym:
  - k_new = largest k in 0..min(SEQ_LEN, hist_len+1) such that the last k symbols of H equal pattern steps 0..k-1. This is longest-suffix-prefix (KMP-correct) fallback.
  - If k_new == SEQ_LEN: match=1 on the next cycle.
    - overlap_en=1: state = largest k<SEQ_LEN satisfying the same rule; history is kept.
    - overlap_en=0: state=0 and hist_len=0.
  - Otherwise state=k_new.
- sym_valid=0: state and history hold; match=0.
- Latency: match, count and state all update on the same edge that accepts the completing symbol. match is registered and high for exactly one cycle.
- count arithmetic:
  - A match with count < 2^CNT_W-1 gives count+1.
  - A match with count at max leaves count unchanged and sets count_ovf=1.
  - clr_count=1 gives count=0 and count_ovf=0.
  - clr_count and a match on the same edge give count=1 and count_ovf=0.
- cfg_load=1: pattern register <= cfg_pattern, state=0, hist_len=0, match=0; count and count_ovf are untouched.
  - cfg_load and sym_valid on the same edge: cfg_load wins and the symbol is discarded.
- overlap_en is sampled on the completing edge only; changing it mid-sequence is legal.
- Reset asserted mid-sequence clears everything immediately. The first symbol after release starts from state 0.
- state never equals SEQ_LEN at an output edge.

Test Plan:
Unless stated, defaults SYM_W=2, SEQ_LEN=4, CNT_W=2.
1. Overlap on: pattern 1,2,1,2; overlap_en=1; stream 1,2,1,2,1,2 -> match pulses after the 4th and 6th symbols; state sequence 1,2,3,2,3,2; count=2.
2. Overlap off: same pattern and stream, overlap_en=0 -> single match after the 4th symbol; state ends at 2; count=1.
3. KMP fallback: pattern 1,1,1,2; stream 1,1,1,1,2 -> state 1,2,3,3, then match; count=1.
4. Saturation: 5 back-to-back non-overlapping matches -> count 1,2,3,3,3; count_ovf rises at the 4th match. Then clr_count with a simultaneous match -> count=1, count_ovf=0.
5. Reset and cfg_load mid-sequence:
   - Reset after 3 correct symbols -> state=0, count=0; a single 4th symbol gives no match.
   - cfg_load together with sym_valid -> symbol dropped, state=0, count preserved.
6. Idle gaps: sym_valid low for 3 cycles between pattern symbols -> state holds during the gap; match still fires after the last symbol; no spurious match pulses.
